// File: rtl/szg_dac_sample_sched.sv
// ---------------------------------------------------------------------------
// szg_dac_sample_sched
//
// Schedules I/Q samples from two streaming sources onto a 12-bit DAC PHY.
// After the PHY PLL reports lock, the output holds mid-scale for
// SETTLE_CYCLES cycles and then streams samples from the granted source.
// Grant changes only between bursts. Losing lock while streaming parks
// the block in FAULT until enable is dropped.
//
// Ports
//   phy_clk, reset            sample clock, synchronous active-high reset
//   enable                    stream request (level)
//   pll_locked                PHY PLL lock, asynchronous to phy_clk
//   src_sel                   requested source, sampled at grant points
//   clr_cnt                   pulse, clears underflow_cnt
//   sN_valid/ready/last       per-source handshake (N = 0,1)
//   sN_data_i, sN_data_q      per-source 12-bit I/Q sample
//   dac_data_i, dac_data_q    registered samples to the DAC
//   dac_active                high in RUN
//   grant                     currently granted source
//   state                     IDLE=0, SETTLE=1, RUN=2, FAULT=3
//   fault                     high in FAULT
//   underflow_cnt             saturating count of RUN cycles with no sample
// ---------------------------------------------------------------------------
module szg_dac_sample_sched #(
    parameter int unsigned  SETTLE_CYCLES = 64,
    parameter logic [11:0]  MIDSCALE      = 12'h800
) (
    input  logic        phy_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pll_locked,
    input  logic        src_sel,
    input  logic        clr_cnt,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic        s0_last,
    input  logic [11:0] s0_data_i,
    input  logic [11:0] s0_data_q,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic        s1_last,
    input  logic [11:0] s1_data_i,
    input  logic [11:0] s1_data_q,
    output logic [11:0] dac_data_i,
    output logic [11:0] dac_data_q,
    output logic        dac_active,
    output logic        grant,
    output logic [1:0]  state,
    output logic        fault,
    output logic [15:0] underflow_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        locked_meta;
    logic        locked_s;
    logic [15:0] settle_cnt;

    logic        run;
    logic        sel_valid;
    logic        sel_last;
    logic [11:0] sel_i;
    logic [11:0] sel_q;
    logic        xfer;
    logic        underflow;

    // pll_locked comes from another clock domain; only locked_s is used.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping enable always takes priority over a lock loss, so a
    // simultaneous drop of both goes quietly to IDLE instead of FAULT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && locked_s) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable || !locked_s) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!locked_s) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counts SETTLE cycles; it is zero on the first SETTLE cycle, so RUN
    // follows after exactly SETTLE_CYCLES cycles of SETTLE.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            settle_cnt <= 16'd0;
        end else if (state_q == ST_SETTLE && state_d == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 16'd1;
        end else begin
            settle_cnt <= 16'd0;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign s0_ready  = run && !grant;
    assign s1_ready  = run && grant;
    assign sel_valid = grant ? s1_valid  : s0_valid;
    assign sel_last  = grant ? s1_last   : s0_last;
    assign sel_i     = grant ? s1_data_i : s0_data_i;
    assign sel_q     = grant ? s1_data_q : s0_data_q;
    assign xfer      = run && sel_valid;
    assign underflow = run && !sel_valid;

    // An empty RUN cycle outputs mid-scale rather than repeating the last
    // sample, so a starved stream never leaves a DC step on the DAC.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            dac_data_i <= MIDSCALE;
            dac_data_q <= MIDSCALE;
        end else if (xfer) begin
            dac_data_i <= sel_i;
            dac_data_q <= sel_q;
        end else begin
            dac_data_i <= MIDSCALE;
            dac_data_q <= MIDSCALE;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset || clr_cnt) begin
            underflow_cnt <= 16'd0;
        end else if (underflow && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    // While streaming, the grant is re-sampled only as a burst closes, so
    // bursts from the two sources never interleave.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            grant <= 1'b0;
        end else if (!run) begin
            grant <= src_sel;
        end else if (xfer && sel_last) begin
            grant <= src_sel;
        end
    end

    assign dac_active = run;
    assign fault      = (state_q == ST_FAULT);
    assign state      = state_q;

endmodule

// File: doc/szg_dac_sample_sched.md
SZG_DAC_SAMPLE_SCHED -- requirements
Module: szg_dac_sample_sched

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64: mid-scale hold cycles after lock, before streaming; legal range 1..65535.
REQ-002 Parameter MIDSCALE, default 12'h800: offset-binary zero code driven whenever no sample is streamed.
REQ-003 phy_clk  in  1  sample clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high; clock phy_clk.
REQ-005 enable  in  1  level; 1 = stream requested; phy_clk domain.
REQ-006 pll_locked  in  1  PHY PLL lock; asynchronous to phy_clk.
REQ-007 src_sel  in  1  requested source (0 = s0, 1 = s1); sampled only at grant points.
REQ-008 clr_cnt  in  1  single-cycle pulse; clears underflow_cnt.
REQ-009 sN_valid / sN_ready / sN_last  in / out / in  1 each  per-source handshake, N = 0,1.
REQ-010 sN_data_i, sN_data_q  in  12 each  per-source I and Q sample.
REQ-011 dac_data_i, dac_data_q  out  12 each  registered samples to the DAC PHY.
REQ-012 dac_active  out  1  high only in RUN.
REQ-013 grant  out  1  currently granted source.
REQ-014 state  out  2  IDLE=0, SETTLE=1, RUN=2, FAULT=3.
REQ-015 fault  out  1  high only in FAULT.
REQ-016 underflow_cnt  out  16  saturating count of RUN cycles with no sample.

Function
REQ-017 pll_locked SHALL pass a 2-flop synchronizer (locked_s); only locked_s is used; synchronizer flops reset to 0.
REQ-018 IDLE: enable=1 and locked_s=1 -> SETTLE with settle counter loaded to 0; otherwise stay.
REQ-019 SETTLE: enable=0 -> IDLE; else locked_s=0 -> IDLE; else counter increments each cycle; -> RUN on the cycle the counter equals SETTLE_CYCLES-1.
REQ-020 RUN: enable=0 -> IDLE; else locked_s=0 -> FAULT; else stay.
REQ-021 FAULT: stay while enable=1; enable=0 -> IDLE.
REQ-022 Simultaneous enable=0 and locked_s=0: enable wins (-> IDLE, no FAULT).
REQ-023 sN_ready SHALL be combinational: 1 iff state=RUN and grant=N; the non-granted source always sees ready=0.
REQ-024 A transfer occurs on a cycle with sN_valid=1 and sN_ready=1; the data appear on dac_data_i/q the following cycle (latency 1).
REQ-025 In RUN, granted valid=0: next-cycle dac_data_i/q = MIDSCALE (no hold of last sample) and underflow_cnt increments.
REQ-026 In IDLE, SETTLE and FAULT: dac_data_i/q SHALL be MIDSCALE from the cycle after entry.
REQ-027 underflow_cnt saturates at 16'hFFFF; it does not count outside RUN.
REQ-028 clr_cnt=1 sets underflow_cnt to 0 next cycle; same-cycle clr_cnt and underflow: clear wins (result 0).
REQ-029 Outside RUN, grant <= src_sel every cycle.
REQ-030 In RUN, grant <= src_sel only on the cycle after a transfer with last=1; otherwise grant holds (bursts never interleave).
REQ-031 Leaving RUN mid-burst abandons the burst; no data are consumed after the exit cycle; re-entry starts a fresh burst.
REQ-032 A held-high src_sel change during a burst takes effect after that burst's last transfer; a source with valid=0 still holds grant.

Reset
REQ-033 On reset: state=IDLE, grant=0, dac_data_i/q=MIDSCALE, dac_active=0, fault=0, underflow_cnt=0, settle counter=0, synchronizer=0.
REQ-034 reset overrides all inputs, including clr_cnt and enable; reset asserted in RUN returns to IDLE next cycle with MIDSCALE output.

Verification
REQ-035 SETTLE_CYCLES=64, enable=1, pll_locked rises at t: RUN entered exactly 2+1+64 cycles after t (sync, IDLE->SETTLE, settle); dac_data=12'h800 throughout.
REQ-036 RUN, grant=0, s0 sends I=0x123,Q=0xABC with valid=1: dac_data_i=0x123, dac_data_q=0xABC one cycle later; s1_ready=0 throughout.
REQ-037 src_sel toggled to 1 mid s0 burst of 8 (last on beat 8): s0 accepts all 8 beats, grant=1 on cycle after beat 8, s1 data follows.
REQ-038 RUN, s0_valid=0 for 5 cycles then clr_cnt together with a 6th empty cycle: underflow_cnt=5 then 0; preset to 0xFFFF + one underflow stays 0xFFFF.
REQ-039 pll_locked drops in RUN: FAULT after 2-cycle sync latency, fault=1, ready=0, MIDSCALE; lock restored alone keeps FAULT; enable=0 -> IDLE.
REQ-040 enable=0 and pll_locked=0 arriving at the same synchronized cycle: state goes RUN -> IDLE, fault never asserts.
